// File: rtl/ex_rt_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package   : qu_common
// Purpose   : Shared defaults and payload type for the back-end retire queue
//             (ex_rt_queue) and its users.
// Contents  : QU_DEF_WIDTH / QU_DEF_DEPTH / QU_DEF_WR_PORTS default sizes,
//             ex_rt_payload_t payload typedef.
// Revision  : 1.0 - initial release
// ============================================================================
package qu_common;

  localparam int QU_DEF_WIDTH    = 32;
  localparam int QU_DEF_DEPTH    = 8;
  localparam int QU_DEF_WR_PORTS = 2;

  // One execute->retire payload word as carried by the queue.
  typedef logic [QU_DEF_WIDTH-1:0] ex_rt_payload_t;

endpackage : qu_common
`default_nettype wire

// File: rtl/ex_rt_queue_wr_compact.sv
`default_nettype none
// ============================================================================
// Module    : wr_compact
// Purpose   : Purely combinational write-lane compactor. For each lane it
//             produces the slot offset (number of accepted lanes below it) and
//             the total number of accepted lanes.
// Ports     : i_acc    [WR_PORTS]        accepted-lane mask
//             o_offs   [WR_PORTS*OFF_W]  lane i offset at [i*OFF_W +: OFF_W]
//             o_total  [OFF_W]           popcount of i_acc
// Revision  : 1.0 - initial release
// ============================================================================
module wr_compact #(
  parameter int WR_PORTS = 2,
  parameter int OFF_W    = $clog2(WR_PORTS + 1)
) (
  input  logic [WR_PORTS-1:0]       i_acc,
  output logic [WR_PORTS*OFF_W-1:0] o_offs,
  output logic [OFF_W-1:0]          o_total
);

  logic [OFF_W-1:0] w_run;

  // Exclusive prefix sum: a lane's offset counts only accepted lanes below it,
  // so lanes with no request never consume a slot.
  always_comb begin
    o_offs  = '0;
    w_run   = '0;
    for (int i = 0; i < WR_PORTS; i++) begin
      o_offs[i*OFF_W +: OFF_W] = w_run;
      w_run = w_run + OFF_W'(i_acc[i]);
    end
    o_total = w_run;
  end

endmodule : wr_compact
`default_nettype wire

// File: rtl/ex_rt_queue.sv
`default_nettype none
// ============================================================================
// Module    : ex_rt_queue
// Purpose   : Multi-lane-write, single-read circular queue between execute
//             and retire. Accepted writes are packed in lane order from the
//             tail; the head is presented first-word-fall-through.
// Ports     : clk, rst (async, active-high), flush (sync discard)
//             wr_en[WR_PORTS], wr_data[WR_PORTS*WIDTH], wr_ready
//             rd_valid, rd_data[WIDTH], rd_ready
//             count[$clog2(DEPTH+1)], almost_full, overflow (sticky)
// Revision  : 1.0 - initial release
// ============================================================================
module ex_rt_queue
  import qu_common::*;
#(
  parameter int WIDTH     = QU_DEF_WIDTH,
  parameter int DEPTH     = QU_DEF_DEPTH,     // power of two, >= 4, >= 2*WR_PORTS
  parameter int WR_PORTS  = QU_DEF_WR_PORTS,  // 1..4
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [WR_PORTS-1:0]       wr_en,
  input  logic [WR_PORTS*WIDTH-1:0] wr_data,
  output logic                      wr_ready,
  output logic                      rd_valid,
  output logic [WIDTH-1:0]          rd_data,
  input  logic                      rd_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                      almost_full,
  output logic                      overflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_OFF_W = $clog2(WR_PORTS + 1);

  logic [WIDTH-1:0]            r_mem [DEPTH];
  logic [c_PTR_W-1:0]          r_head;
  logic [c_PTR_W-1:0]          r_tail;
  logic [c_CNT_W-1:0]          r_count;
  logic                        r_overflow;

  logic                        w_wr_ready;
  logic [WR_PORTS-1:0]         w_acc;
  logic                        w_pop;
  logic                        w_ovf_evt;
  logic [WR_PORTS*c_OFF_W-1:0] w_offs;
  logic [c_OFF_W-1:0]          w_total;
  logic [c_PTR_W-1:0]          w_slot [WR_PORTS];

  // Space check uses the registered count only: a pop in the same cycle
  // never grants extra room, keeping wr_ready free of any rd_ready path.
  assign w_wr_ready = (c_CNT_W'(DEPTH) - r_count) >= c_CNT_W'(WR_PORTS);

  // A write is all-or-nothing at the queue level: either every requesting
  // lane is accepted or the whole group is dropped and flagged.
  assign w_acc     = wr_en & {WR_PORTS{w_wr_ready && !flush}};
  assign w_pop     = (r_count != '0) && rd_ready && !flush;
  assign w_ovf_evt = (|wr_en) && !w_wr_ready && !flush;

  wr_compact #(
    .WR_PORTS (WR_PORTS),
    .OFF_W    (c_OFF_W)
  ) u_wr_compact (
    .i_acc   (w_acc),
    .o_offs  (w_offs),
    .o_total (w_total)
  );

  // Slot index wraps naturally in c_PTR_W bits, so a group straddling the
  // end of the ring lands in DEPTH-1 then 0.
  always_comb begin
    for (int i = 0; i < WR_PORTS; i++) begin
      w_slot[i] = r_tail + c_PTR_W'(w_offs[i*c_OFF_W +: c_OFF_W]);
    end
  end

  // Payload storage has no reset: stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_PORTS; i++) begin
      if (w_acc[i]) begin
        r_mem[w_slot[i]] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tail  <= r_tail + c_PTR_W'(w_total);
      r_head  <= r_head + c_PTR_W'(w_pop);
      r_count <= r_count + c_CNT_W'(w_total) - c_CNT_W'(w_pop);
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign wr_ready    = w_wr_ready;
  assign rd_valid    = (r_count != '0);
  assign rd_data     = r_mem[r_head];
  assign count       = r_count;
  assign almost_full = (r_count >= c_CNT_W'(AF_THRESH));
  assign overflow    = r_overflow;

endmodule : ex_rt_queue
`default_nettype wire

// File: tb/tb_ex_rt_queue.sv
`default_nettype none
// ============================================================================
// Module    : tb_ex_rt_queue
// Purpose   : Self-checking bench for ex_rt_queue (WIDTH=16, DEPTH=8,
//             WR_PORTS=2): table of directed vectors plus hand-written
//             sequences for ring wrap, flush and asynchronous reset.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_ex_rt_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  wr_en;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_ready;
  logic [3:0]  count;
  logic        almost_full;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_rt_queue #(
    .WIDTH     (16),
    .DEPTH     (8),
    .WR_PORTS  (2),
    .AF_THRESH (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  typedef struct {
    logic [1:0]  we;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rd;
    logic        fl;
    logic        ev;   // expected rd_valid
    logic        cd;   // compare rd_data
    logic [15:0] ed;
    logic [3:0]  ec;
    logic        ewr;
    logic        eaf;
    logic        eov;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, let the edge take it, sample #1 after.
  task automatic step(input logic [1:0] we, input logic [15:0] d0, input logic [15:0] d1,
                      input logic rd, input logic fl);
    wr_en    = we;
    wr_data  = {d1, d0};
    rd_ready = rd;
    flush    = fl;
    @(posedge clk);
    #1;
    wr_en    = 2'b00;
    wr_data  = '0;
    rd_ready = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            we     d0      d1      rd    fl    ev    cd    ed      ec    wr    af    ov
    vt[0]  = '{2'b11, 16'hA,  16'hB,  1'b0, 1'b0, 1'b1, 1'b1, 16'hA,  4'd2, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{2'b00, 16'h0,  16'h0,  1'b1, 1'b0, 1'b1, 1'b1, 16'hB,  4'd1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{2'b00, 16'h0,  16'h0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0,  4'd0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{2'b10, 16'h0,  16'h55, 1'b0, 1'b0, 1'b1, 1'b1, 16'h55, 4'd1, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{2'b00, 16'h0,  16'h0,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0,  4'd0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{2'b11, 16'h10, 16'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h10, 4'd2, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{2'b11, 16'h12, 16'h13, 1'b0, 1'b0, 1'b1, 1'b1, 16'h10, 4'd4, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{2'b11, 16'h14, 16'h15, 1'b0, 1'b0, 1'b1, 1'b1, 16'h10, 4'd6, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{2'b01, 16'h16, 16'h0,  1'b0, 1'b0, 1'b1, 1'b1, 16'h10, 4'd7, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{2'b01, 16'h99, 16'h0,  1'b0, 1'b0, 1'b1, 1'b1, 16'h10, 4'd7, 1'b0, 1'b1, 1'b1};
    vt[10] = '{2'b00, 16'h0,  16'h0,  1'b1, 1'b0, 1'b1, 1'b1, 16'h11, 4'd6, 1'b1, 1'b1, 1'b1};
    vt[11] = '{2'b11, 16'h20, 16'h21, 1'b1, 1'b0, 1'b1, 1'b1, 16'h12, 4'd7, 1'b0, 1'b1, 1'b1};
    vt[12] = '{2'b11, 16'h30, 16'h31, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0,  4'd0, 1'b1, 1'b0, 1'b0};

    rst      = 1'b1;
    flush    = 1'b0;
    wr_en    = 2'b00;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", 32'(count), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset almost_full", 32'(almost_full), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 13; v++) begin
      step(vt[v].we, vt[v].d0, vt[v].d1, vt[v].rd, vt[v].fl);
      chk($sformatf("vec%0d rd_valid", v), 32'(rd_valid), 32'(vt[v].ev));
      chk($sformatf("vec%0d count", v), 32'(count), 32'(vt[v].ec));
      chk($sformatf("vec%0d wr_ready", v), 32'(wr_ready), 32'(vt[v].ewr));
      chk($sformatf("vec%0d almost_full", v), 32'(almost_full), 32'(vt[v].eaf));
      chk($sformatf("vec%0d overflow", v), 32'(overflow), 32'(vt[v].eov));
      if (vt[v].cd) begin
        chk($sformatf("vec%0d rd_data", v), 32'(rd_data), 32'(vt[v].ed));
      end
    end

    // Ring wrap: bring head=tail=7 with an empty queue, then a 2-lane write
    // must split across slots 7 and 0.
    for (int k = 0; k < 3; k++) step(2'b11, 16'h70, 16'h71, 1'b0, 1'b0);
    step(2'b01, 16'h72, 16'h0, 1'b0, 1'b0);
    chk("wrap prefill count", 32'(count), 32'd7);
    for (int k = 0; k < 7; k++) step(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("wrap drained count", 32'(count), 32'd0);
    chk("wrap drained rd_valid", 32'(rd_valid), 32'd0);
    step(2'b11, 16'h1, 16'h2, 1'b0, 1'b0);
    chk("wrap count", 32'(count), 32'd2);
    chk("wrap first data", 32'(rd_data), 32'h1);
    step(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("wrap second data", 32'(rd_data), 32'h2);
    step(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("wrap final count", 32'(count), 32'd0);

    // Flush wins over a same-cycle write and pop.
    step(2'b11, 16'h81, 16'h82, 1'b0, 1'b0);
    step(2'b11, 16'h83, 16'h84, 1'b0, 1'b0);
    chk("preflush count", 32'(count), 32'd4);
    step(2'b11, 16'h85, 16'h86, 1'b1, 1'b1);
    chk("flush count", 32'(count), 32'd0);
    chk("flush rd_valid", 32'(rd_valid), 32'd0);
    chk("flush overflow", 32'(overflow), 32'd0);
    chk("flush wr_ready", 32'(wr_ready), 32'd1);

    // Asynchronous reset between edges, with a write held during reset.
    step(2'b11, 16'h31, 16'h32, 1'b0, 1'b0);
    step(2'b01, 16'h33, 16'h0, 1'b0, 1'b0);
    chk("prereset count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst count", 32'(count), 32'd0);
    chk("async rst rd_valid", 32'(rd_valid), 32'd0);
    chk("async rst wr_ready", 32'(wr_ready), 32'd1);
    wr_en   = 2'b11;
    wr_data = {16'h42, 16'h41};
    @(posedge clk);
    #1;
    chk("write during rst dropped", 32'(count), 32'd0);
    rst = 1'b0;
    step(2'b11, 16'h51, 16'h52, 1'b0, 1'b0);
    chk("post-rst count", 32'(count), 32'd2);
    chk("post-rst rd_data", 32'(rd_data), 32'h51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ex_rt_queue
`default_nettype wire

// File: doc/ex_rt_queue.md
EX_RT_QUEUE -- requirements
Module: ex_rt_queue

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload bits per entry.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count and SHALL be a power of two, at least 4.
REQ-003 Parameter WR_PORTS, default 2, SHALL set the number of write lanes (1..4); DEPTH SHALL be at least 2*WR_PORTS.
REQ-004 Parameter AF_THRESH, default DEPTH-2, SHALL set the almost_full level.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 flush  in  1  synchronous discard of all contents (mispredict).
REQ-008 wr_en  in  WR_PORTS  per-lane write request.
REQ-009 wr_data  in  WR_PORTS*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH].
REQ-010 wr_ready  out  1  queue can take a full WR_PORTS-wide write this cycle.
REQ-011 rd_valid  out  1  head entry present.
REQ-012 rd_data  out  WIDTH  head payload (first-word-fall-through).
REQ-013 rd_ready  in  1  consumer pops the head when rd_valid is high.
REQ-014 count  out  $clog2(DEPTH+1)  occupied entries.
REQ-015 almost_full  out  1  count >= AF_THRESH.
REQ-016 overflow  out  1  sticky: write attempted while wr_ready was low.

Function
REQ-017 wr_ready SHALL be (DEPTH - count) >= WR_PORTS, from registered count only; a same-cycle pop SHALL NOT raise it.
REQ-018 Accepted writes SHALL be compacted in ascending lane order into consecutive slots from the tail; lanes with wr_en low SHALL consume no slot.
REQ-019 Write accepted = wr_en[i] && wr_ready && !flush; tail SHALL advance by the popcount of accepted lanes.
REQ-020 When any wr_en is high with wr_ready low and no flush, the writes SHALL be dropped and overflow SHALL set and hold.
REQ-021 Pop = rd_valid && rd_ready && !flush; head SHALL advance by one.
REQ-022 count SHALL update each cycle by +accepted writes -pop; simultaneous push and pop SHALL both take effect.
REQ-023 Write-to-rd_valid latency SHALL be 1 cycle; an entry written into an empty queue SHALL appear on rd_data the next cycle.
REQ-024 rd_data SHALL be the head slot contents, combinational from storage; with rd_valid low it SHALL be don't-care.
REQ-025 Pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; a multi-lane write crossing the wrap SHALL split across slots DEPTH-1 and 0.
REQ-026 rd_valid SHALL be count != 0.
REQ-027 flush SHALL take priority over writes and pops in the same cycle: next cycle head=tail=0, count=0, overflow=0.
REQ-028 Storage SHALL not be cleared by flush or reset; only pointers, count and flags.

Reset
REQ-029 Asserting rst SHALL immediately force head=0, tail=0, count=0, overflow=0; hence rd_valid=0, almost_full=0, wr_ready=1.
REQ-030 rst asserted mid-write or mid-pop SHALL discard that transfer; operation SHALL resume on the first edge after deassertion.

Structure
REQ-031 Package qu_common SHALL hold the default WIDTH/DEPTH/WR_PORTS constants and the ex_rt payload typedef used by the back end.
REQ-032 One sub-module, wr_compact, SHALL compute per-lane slot offsets (prefix popcount of accepted lanes) and the total; it SHALL be purely combinational.
REQ-033 The queue SHALL replace both single-port back-end FIFOs, instantiated with WR_PORTS=1 where one lane suffices.

Verification (WIDTH=16, DEPTH=8, WR_PORTS=2)
REQ-034 Reset, then wr_en=2'b11, data {0xB,0xA} -> next cycle rd_valid=1, rd_data=0xA, count=2; pop -> rd_data=0xB.
REQ-035 wr_en=2'b10, data lane1=0x55 -> count=1 and rd_data=0x55 (lane 0 consumed no slot).
REQ-036 Fill to count=7 -> wr_ready=0, almost_full=1; write 2'b01 -> count stays 7, overflow=1 and holds until flush.
REQ-037 head=tail=7 with count=0; write {0x2,0x1} -> slots 7 and 0 used; pops return 0x1 then 0x2; count=0.
REQ-038 count=4, flush with wr_en=2'b11 and rd_ready=1 in the same cycle -> next cycle count=0, rd_valid=0, overflow=0.
REQ-039 count=3, rst pulsed asynchronously between edges -> count=0 and rd_valid=0 before the next edge; writes succeed after release.
